// File: rtl/inst_mem_seq.sv
// Run-time loadable instruction memory with a registered fetch port.
// Clears itself to NOP after every reset before fetches are accepted.
module inst_mem_seq #(
  parameter int DEPTH = 32,
  parameter int PC_W  = 32,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fetch_req,
  input  logic [PC_W-1:0] fetch_pc,
  input  logic            fetch_stall,
  output logic            fetch_ready,
  output logic            inst_valid,
  output logic [31:0]     inst,
  output logic            inst_err,
  input  logic            load_we,
  input  logic [AW-1:0]   load_addr,
  input  logic [31:0]     load_data,
  output logic            init_done
);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t        r_state;
  logic [AW-1:0] r_clr_ptr;
  logic [31:0]   r_inst;
  logic          r_inst_valid;
  logic          r_inst_err;
  logic          r_init_done;

  logic [31:0]   r_mem [DEPTH];

  logic          w_accept;
  logic [AW-1:0] w_word;
  logic          w_pc_hi_nz;
  logic          w_err;
  logic          w_mem_we;
  logic [AW-1:0] w_mem_addr;
  logic [31:0]   w_mem_wdata;

  // Bits above the word index exist only when the PC is wider than the memory.
  generate
    if (PC_W > AW + 2) begin : g_pc_hi
      assign w_pc_hi_nz = |fetch_pc[PC_W-1:AW+2];
    end else begin : g_pc_no_hi
      assign w_pc_hi_nz = 1'b0;
    end
  endgenerate

  assign w_word      = fetch_pc[AW+1:2];
  assign w_err       = (fetch_pc[1:0] != 2'b00) | w_pc_hi_nz;
  assign fetch_ready = (r_state == ST_RUN) & ~load_we & ~fetch_stall;
  assign w_accept    = fetch_req & fetch_ready;

  // Single write port shared by the clear sweep and the loader.
  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_addr  = load_addr;
    w_mem_wdata = load_data;
    if (!rst) begin
      if (r_state == ST_CLEAR) begin
        w_mem_we    = 1'b1;
        w_mem_addr  = r_clr_ptr;
        w_mem_wdata = 32'h0;
      end else begin
        w_mem_we    = load_we;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_CLEAR;
      r_clr_ptr    <= '0;
      r_inst       <= 32'h0;
      r_inst_valid <= 1'b0;
      r_inst_err   <= 1'b0;
      r_init_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          if (r_clr_ptr == AW'(DEPTH - 1)) begin
            r_state     <= ST_RUN;
            r_init_done <= 1'b1;
          end else begin
            r_clr_ptr <= r_clr_ptr + 1'b1;
          end
        end
        ST_RUN: begin
          // A stall freezes the result even when a load happens alongside it.
          if (fetch_stall) begin
            r_inst       <= r_inst;
            r_inst_valid <= r_inst_valid;
            r_inst_err   <= r_inst_err;
          end else if (w_accept) begin
            r_inst       <= w_err ? 32'h0 : r_mem[w_word];
            r_inst_err   <= w_err;
            r_inst_valid <= 1'b1;
          end else begin
            r_inst_valid <= 1'b0;
            r_inst_err   <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_CLEAR;
        end
      endcase
    end
  end

  assign inst       = r_inst;
  assign inst_valid = r_inst_valid;
  assign inst_err   = r_inst_err;
  assign init_done  = r_init_done;

endmodule

// File: tb/tb_inst_mem_seq.sv
// Directed bench for inst_mem_seq: reset sweep, loads, fetches, errors,
// stalls, load/fetch collisions and reset mid-run.
module tb_inst_mem_seq;

  localparam int DEPTH = 32;
  localparam int PC_W  = 32;
  localparam int AW    = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic            fetch_req;
  logic [PC_W-1:0] fetch_pc;
  logic            fetch_stall;
  logic            fetch_ready;
  logic            inst_valid;
  logic [31:0]     inst;
  logic            inst_err;
  logic            load_we;
  logic [AW-1:0]   load_addr;
  logic [31:0]     load_data;
  logic            init_done;

  int checks   = 0;
  int failures = 0;

  inst_mem_seq #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_req   (fetch_req),
    .fetch_pc    (fetch_pc),
    .fetch_stall (fetch_stall),
    .fetch_ready (fetch_ready),
    .inst_valid  (inst_valid),
    .inst        (inst),
    .inst_err    (inst_err),
    .load_we     (load_we),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .init_done   (init_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        req;
    logic [31:0] pc;
    logic        stall;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        exp_ready;
    logic        exp_valid;
    logic        exp_err;
    logic [31:0] exp_inst;
  } vec_t;

  vec_t vecs[$];
  logic [31:0] prog [20];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input string nm, input logic req, input logic [31:0] pc,
                              input logic stall, input logic we, input logic [4:0] addr,
                              input logic [31:0] data, input logic rdy, input logic vld,
                              input logic err, input logic [31:0] ins);
    vec_t v;
    v.name = nm; v.req = req; v.pc = pc; v.stall = stall; v.we = we;
    v.addr = addr; v.data = data; v.exp_ready = rdy; v.exp_valid = vld;
    v.exp_err = err; v.exp_inst = ins;
    return v;
  endfunction

  // One cycle: drive on the falling edge, check ready before the rising edge,
  // check the registered outputs just after it.
  task automatic step(input vec_t v);
    @(negedge clk);
    fetch_req   = v.req;
    fetch_pc    = v.pc;
    fetch_stall = v.stall;
    load_we     = v.we;
    load_addr   = v.addr;
    load_data   = v.data;
    #1;
    chk({v.name, ".ready"}, 32'(fetch_ready), 32'(v.exp_ready));
    @(posedge clk);
    #1;
    chk({v.name, ".valid"}, 32'(inst_valid), 32'(v.exp_valid));
    chk({v.name, ".err"},   32'(inst_err),   32'(v.exp_err));
    chk({v.name, ".inst"},  inst,            v.exp_inst);
    $display("vec %s req=%0b pc=%08h stall=%0b we=%0b -> valid=%0b err=%0b inst=%08h",
             v.name, v.req, v.pc, v.stall, v.we, inst_valid, inst_err, inst);
  endtask

  task automatic idle_inputs();
    fetch_req = 1'b0; fetch_pc = '0; fetch_stall = 1'b0;
    load_we = 1'b0; load_addr = '0; load_data = '0;
  endtask

  initial begin
    int n;
    prog[0]  = 32'h24010001; prog[1]  = 32'h00011100; prog[2]  = 32'h00411821;
    prog[3]  = 32'h00622024; prog[4]  = 32'h00832825; prog[5]  = 32'h00A43022;
    prog[6]  = 32'h00C5382A; prog[7]  = 32'hAC070004; prog[8]  = 32'h8C080004;
    prog[9]  = 32'h11000002; prog[10] = 32'h20090005; prog[11] = 32'h012A5820;
    prog[12] = 32'h016B6020; prog[13] = 32'h3C0D1234; prog[14] = 32'h35AD5678;
    prog[15] = 32'h000D7080; prog[16] = 32'h000E7882; prog[17] = 32'h01CF8026;
    prog[18] = 32'h02108827; prog[19] = 32'h08000000;

    // Loads: outputs stay idle, inst holds the zero from the first fetch.
    for (int i = 0; i < 20; i++)
      vecs.push_back(mk($sformatf("load%0d", i), 1'b0, 32'h0, 1'b0, 1'b1, 5'(i), prog[i],
                        1'b0, 1'b0, 1'b0, 32'h0));
    vecs.push_back(mk("load31", 1'b0, 32'h0, 1'b0, 1'b1, 5'd31, 32'h1234ABCD, 1'b0, 1'b0, 1'b0, 32'h0));
    vecs.push_back(mk("f00",    1'b1, 32'h00, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h24010001));
    vecs.push_back(mk("f04",    1'b1, 32'h04, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h00011100));
    vecs.push_back(mk("f08",    1'b1, 32'h08, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h00411821));
    vecs.push_back(mk("idle1",  1'b0, 32'h00, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h00411821));
    vecs.push_back(mk("mis06",  1'b1, 32'h06, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h0));
    vecs.push_back(mk("oor80",  1'b1, 32'h80, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h0));
    vecs.push_back(mk("f7c",    1'b1, 32'h7C, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h1234ABCD));
    vecs.push_back(mk("f04b",   1'b1, 32'h04, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h00011100));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk($sformatf("stall%0d", i), 1'b1, 32'h08, 1'b1, 1'b0, 5'd0, 32'h0,
                        1'b0, 1'b1, 1'b0, 32'h00011100));
    vecs.push_back(mk("rel08",  1'b1, 32'h08, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h00411821));
    vecs.push_back(mk("idle2",  1'b0, 32'h00, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h00411821));
    vecs.push_back(mk("coll",   1'b1, 32'h08, 1'b0, 1'b1, 5'd2, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 32'h00411821));
    vecs.push_back(mk("retry",  1'b1, 32'h08, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 1'b0, 32'hDEADBEEF));
    vecs.push_back(mk("stldw",  1'b1, 32'h0C, 1'b1, 1'b1, 5'd3, 32'hCAFEF00D, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF));
    vecs.push_back(mk("f0c",    1'b1, 32'h0C, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 1'b0, 32'hCAFEF00D));
    vecs.push_back(mk("mis02",  1'b1, 32'h02, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h0));
    vecs.push_back(mk("oor100", 1'b1, 32'h100, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h0));
    vecs.push_back(mk("oormsb", 1'b1, 32'h80000000, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h0));
    vecs.push_back(mk("f4c",    1'b1, 32'h4C, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h08000000));

    // Reset held for two edges, then check reset values.
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst.inst",  inst,              32'h0);
    chk("rst.valid", 32'(inst_valid),   32'h0);
    chk("rst.err",   32'(inst_err),     32'h0);
    chk("rst.done",  32'(init_done),    32'h0);
    chk("rst.ready", 32'(fetch_ready),  32'h0);
    rst = 1'b0;

    // Sweep takes exactly DEPTH edges after rst drops.
    n = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (init_done !== 1'b0 || fetch_ready !== 1'b0) n++;
      @(negedge clk);
    end
    chk("sweep.early_done", 32'(n), 32'h0);
    chk("sweep.done",  32'(init_done),   32'h1);
    chk("sweep.ready", 32'(fetch_ready), 32'h1);
    $display("sweep finished: init_done=%0b fetch_ready=%0b", init_done, fetch_ready);

    step(mk("first00", 1'b1, 32'h00, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0));

    foreach (vecs[i]) step(vecs[i]);

    // Reset mid-run: outputs clear at the reset edge, then sweep again.
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid.inst",  inst,             32'h0);
    chk("mid.valid", 32'(inst_valid),  32'h0);
    chk("mid.done",  32'(init_done),   32'h0);
    $display("mid-run reset: inst=%08h valid=%0b init_done=%0b", inst, inst_valid, init_done);
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    while (init_done !== 1'b1 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("mid.sweep_edges", 32'(n), 32'd32);
    step(mk("clr00", 1'b1, 32'h00, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0));
    step(mk("clr7c", 1'b1, 32'h7C, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

endmodule
